// File: rtl/ray_generator_pkg.sv
// ---------------------------------------------------------------------------
// ray_generator_pkg
// Shared types and constants for the camera ray generator.
//   vec3_t  : three packed 32-bit two's complement components (x, y, z)
//   Q_BITS  : fractional bits of every vector component (format tag only)
//   state_e : ray generator frame state
//   pixW()  : width of a pixel counter for a given resolution (min 1 bit)
// ---------------------------------------------------------------------------
package ray_generator_pkg;

  localparam int Q_BITS = 10;

  typedef logic signed [0:2][31:0] vec3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A resolution of 1 still needs a one-bit counter so the ports exist.
  function automatic int pixW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_generator_if.sv
// ---------------------------------------------------------------------------
// ray_generator_if
// Ray output bus between the ray generator (master) and its consumer (slave).
//   out_valid : ray fields are valid            (master -> slave)
//   out_ready : consumer accepts ray this cycle (slave -> master)
//   origin    : ray origin                      (master -> slave)
//   dir       : ray direction                   (master -> slave)
//   pix_x     : column of current ray, XW bits  (master -> slave)
//   pix_y     : row of current ray, YW bits     (master -> slave)
//   last      : current ray is the frame's last (master -> slave)
// ---------------------------------------------------------------------------
interface ray_generator_if #(
  parameter int XW = 6,
  parameter int YW = 6
);
  import ray_generator_pkg::*;

  logic          out_valid;
  logic          out_ready;
  vec3_t         origin;
  vec3_t         dir;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          last;

  modport master (
    output out_valid, origin, dir, pix_x, pix_y, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, origin, dir, pix_x, pix_y, last,
    output out_ready
  );

endinterface

// File: rtl/ray_generator_vadd.sv
// ---------------------------------------------------------------------------
// ray_generator_vadd
// Combinational per-component vector add, wrapping modulo 2^32.
//   a, b : input vectors
//   sum  : a + b, component by component
// ---------------------------------------------------------------------------
module ray_generator_vadd
  import ray_generator_pkg::*;
(
  input  vec3_t a,
  input  vec3_t b,
  output vec3_t sum
);

  // Each component is an independent 32-bit add; carries never cross
  // component boundaries.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i] = a[i] + b[i];
    end
  end

endmodule

// File: rtl/ray_generator.sv
// ---------------------------------------------------------------------------
// ray_generator
// Sweeps an H_RES x V_RES raster and emits one camera ray per pixel over a
// valid/ready handshake. Directions are accumulated with adders only:
// dir(x,y) = corner + x*step_u + y*step_v.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : begin a frame (only looked at while idle)
//   cam_origin : camera position, captured on an accepted start
//   corner     : direction of pixel (0,0), captured on an accepted start
//   step_u     : per-column direction increment, captured on start
//   step_v     : per-row direction increment, captured on start
//   ray        : ray output bus (master side)
//   busy       : a frame is in progress (state is not IDLE)
//   done       : one-cycle pulse after the final ray is accepted
// ---------------------------------------------------------------------------
module ray_generator
  import ray_generator_pkg::*;
#(
  parameter int H_RES = 64,
  parameter int V_RES = 48
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  start,
  input  vec3_t cam_origin,
  input  vec3_t corner,
  input  vec3_t step_u,
  input  vec3_t step_v,
  ray_generator_if.master ray,
  output logic  busy,
  output logic  done
);

  localparam int XW = pixW(H_RES);
  localparam int YW = pixW(V_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  state_e        state_q,   state_d;
  logic          valid_q,   valid_d;
  vec3_t         origin_q,  origin_d;
  vec3_t         stepU_q,   stepU_d;
  vec3_t         stepV_q,   stepV_d;
  vec3_t         dir_q,     dir_d;
  vec3_t         rowBase_q, rowBase_d;
  logic [XW-1:0] pixX_q,    pixX_d;
  logic [YW-1:0] pixY_q,    pixY_d;

  vec3_t dirPlusU;
  vec3_t rowPlusV;
  logic  handshake;

  // Next pixel along the row.
  ray_generator_vadd uAddU (
    .a   (dir_q),
    .b   (stepU_q),
    .sum (dirPlusU)
  );

  // First pixel of the next row; rowBase_q tracks the start of the current
  // row so row wraps never have to undo the column accumulation.
  ray_generator_vadd uAddV (
    .a   (rowBase_q),
    .b   (stepV_q),
    .sum (rowPlusV)
  );

  assign handshake = valid_q && ray.out_ready;

  // Next-state logic: capture the camera on start, advance the raster on
  // each accepted ray, and retire the frame after the final pixel.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    origin_d  = origin_q;
    stepU_d   = stepU_q;
    stepV_d   = stepV_q;
    dir_d     = dir_q;
    rowBase_d = rowBase_q;
    pixX_d    = pixX_q;
    pixY_d    = pixY_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          origin_d  = cam_origin;
          stepU_d   = step_u;
          stepV_d   = step_v;
          dir_d     = corner;
          rowBase_d = corner;
          pixX_d    = '0;
          pixY_d    = '0;
          valid_d   = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (handshake) begin
          if (pixX_q != X_LAST) begin
            pixX_d = pixX_q + 1'b1;
            dir_d  = dirPlusU;
          end else if (pixY_q != Y_LAST) begin
            pixX_d    = '0;
            pixY_d    = pixY_q + 1'b1;
            rowBase_d = rowPlusV;
            dir_d     = rowPlusV;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      origin_q  <= '0;
      stepU_q   <= '0;
      stepV_q   <= '0;
      dir_q     <= '0;
      rowBase_q <= '0;
      pixX_q    <= '0;
      pixY_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      origin_q  <= origin_d;
      stepU_q   <= stepU_d;
      stepV_q   <= stepV_d;
      dir_q     <= dir_d;
      rowBase_q <= rowBase_d;
      pixX_q    <= pixX_d;
      pixY_q    <= pixY_d;
    end
  end

  assign ray.out_valid = valid_q;
  assign ray.origin    = origin_q;
  assign ray.dir       = dir_q;
  assign ray.pix_x     = pixX_q;
  assign ray.pix_y     = pixY_q;
  assign ray.last      = valid_q && (pixX_q == X_LAST) && (pixY_q == Y_LAST);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
